// File: rtl/spi_master_arb.sv
// rtl/spi_master_arb.sv - round-robin arbitrated SPI master, one LSB-first frame per grant
package spi_pkg;
  localparam int DWIDTH = 8;
  localparam int AWIDTH = 8;
endpackage

module spi_master_arb
  import spi_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int CLK_DIV = 2,
  parameter  int FW      = DWIDTH + AWIDTH + 3,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0][FW-1:0]  req_frame,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [FW-1:0]            rsp_data,
  output logic                     busy,
  output logic                     sck,
  output logic                     mosi,
  output logic                     ss_n,
  input  logic                     miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * FW + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * FW - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   div_cnt;
  logic [EW-1:0]   edge_cnt;
  logic [1:0]      mode_q;
  logic [IDW-1:0]  last_grant, cur_id, grant_id, cand;
  logic            grant_any, tick, sample;
  logic [FW-1:0]   tx, rx;

  assign tick   = (div_cnt == '0);
  // edge_cnt is even before a leading edge; CPHA flips which edge samples
  assign sample = ~edge_cnt[0] ^ mode_q[0];

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_grant) + i) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any && !rst) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    ss_n       = 1'b1;
    case (state)
      IDLE:  if (grant_any) state_next = SETUP;
      SETUP: begin
        ss_n = 1'b0;
        if (tick) state_next = XFER;
      end
      XFER: begin
        ss_n = 1'b0;
        if (tick && edge_cnt == EDGE_LAST) state_next = HOLD;
      end
      HOLD: begin
        ss_n = 1'b0;
        if (tick) state_next = GAP;
      end
      GAP:   if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= DIV_LAST;
      edge_cnt   <= '0;
      mode_q     <= '0;
      last_grant <= IDW'(NREQ - 1);
      cur_id     <= '0;
      tx         <= '0;
      rx         <= '0;
      sck        <= 1'b0;
      mosi       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state_next != state || tick) div_cnt <= DIV_LAST;
      else                             div_cnt <= div_cnt - 1'b1;
      case (state)
        IDLE: begin
          // live mode is used at the grant edge so it matches mode_q for the frame
          mode_q <= mode;
          sck    <= mode[1];
          if (grant_any) begin
            last_grant <= grant_id;
            cur_id     <= grant_id;
            edge_cnt   <= '0;
            if (!mode[0]) begin
              mosi <= req_frame[grant_id][0];
              tx   <= req_frame[grant_id] >> 1;
            end else begin
              tx   <= req_frame[grant_id];
            end
          end
        end
        XFER: if (tick) begin
          sck      <= ~sck;
          edge_cnt <= edge_cnt + 1'b1;
          if (sample) begin
            rx <= {miso, rx[FW-1:1]};
          end else if (edge_cnt != EDGE_LAST) begin
            mosi <= tx[0];
            tx   <= tx >> 1;
          end
        end
        HOLD: begin
          sck <= mode_q[1];
          if (tick) begin
            rsp_valid <= 1'b1;
            rsp_id    <= cur_id;
            rsp_data  <= rx;
          end
        end
        default: sck <= mode_q[1];
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arb.sv
// tb/tb_spi_master_arb.sv - directed self-checking bench for spi_master_arb
module tb_spi_master_arb;
  localparam int FW = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           mode;
  logic [1:0]           req_valid;
  logic [1:0][FW-1:0]   req_frame;
  logic [1:0]           req_ready;
  logic                 rsp_valid;
  logic [0:0]           rsp_id;
  logic [FW-1:0]        rsp_data;
  logic                 busy, sck, mosi, ss_n, miso;

  logic [0:0]           req_valid1, req_ready1, rsp_id1;
  logic [0:0][FW-1:0]   req_frame1;
  logic                 rsp_valid1, busy1, sck1, mosi1, ss_n1;
  logic [FW-1:0]        rsp_data1;

  logic                 loopback;
  logic                 sl_miso = 1'b0, prev_ss = 1'b1, prev_sck = 1'b0;
  logic [1:0]           sl_mode = 2'b00;
  logic [FW-1:0]        sl_pat, sl_sh = '0, sl_rx = '0;
  int                   sl_edges = 0, ss_low = 0, gap_cnt = 0, last_gap = 0, rsp_cnt = 0;
  int                   errors = 0, checks = 0;

  assign miso = loopback ? mosi : sl_miso;

  spi_master_arb #(.NREQ(2), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .mode(mode), .req_valid(req_valid), .req_frame(req_frame),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .sck(sck), .mosi(mosi), .ss_n(ss_n), .miso(miso)
  );

  spi_master_arb #(.NREQ(1), .CLK_DIV(2)) dut1 (
    .clk(clk), .rst(rst), .mode(2'b00), .req_valid(req_valid1), .req_frame(req_frame1),
    .req_ready(req_ready1), .rsp_valid(rsp_valid1), .rsp_id(rsp_id1), .rsp_data(rsp_data1),
    .busy(busy1), .sck(sck1), .mosi(mosi1), .ss_n(ss_n1), .miso(mosi1)
  );

  // SPI slave: shifts sl_pat out and captures mosi using the mode seen when ss_n fell
  always @(negedge clk) begin
    if (prev_ss && !ss_n) begin
      sl_mode  = mode;
      sl_sh    = sl_pat;
      sl_rx    = '0;
      sl_edges = 0;
      ss_low   = 0;
      last_gap = gap_cnt;
      gap_cnt  = 0;
      if (!sl_mode[0]) begin
        sl_miso = sl_sh[0];
        sl_sh   = sl_sh >> 1;
      end
    end else if (!ss_n && sck !== prev_sck) begin
      sl_edges = sl_edges + 1;
      if (sl_edges[0] ^ sl_mode[0]) begin
        sl_rx = {mosi, sl_rx[FW-1:1]};
      end else begin
        sl_miso = sl_sh[0];
        sl_sh   = sl_sh >> 1;
      end
    end
    if (!ss_n) ss_low = ss_low + 1;
    if (busy && ss_n) gap_cnt = gap_cnt + 1;
    if (rsp_valid) rsp_cnt = rsp_cnt + 1;
    prev_ss  = ss_n;
    prev_sck = sck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      step(1);
      n++;
    end
    check({tag, "_rsp_seen"}, 32'(rsp_valid), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t_prev, pulses, rc;
    rst = 1'b1; mode = 2'b00; req_valid = '0; req_frame = '0; loopback = 1'b1;
    sl_pat = '0; req_valid1 = '0; req_frame1 = '0;
    step(3);
    rst = 1'b0;
    check("rst_ss_n", 32'(ss_n), 32'h1);
    check("rst_sck", 32'(sck), 32'h0);
    check("rst_mosi", 32'(mosi), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(rsp_id), 32'h0);
    check("rst_rsp_data", 32'(rsp_data), 32'h0);

    // single frame, mode 0, looped miso
    req_frame[0] = 19'h5A5A3; req_valid = 2'b01;
    #1;
    check("s1_req_ready", 32'(req_ready), 32'h1);
    step(1);
    req_valid = 2'b00;
    wait_rsp("s1");
    check("s1_rsp_id", 32'(rsp_id), 32'h0);
    check("s1_rsp_data", 32'(rsp_data), 32'h5A5A3);
    check("s1_ss_low_cycles", 32'(ss_low), 32'd80);
    check("s1_sck_edges", 32'(sl_edges), 32'd38);
    check("s1_mosi_bits", 32'(sl_rx), 32'h5A5A3);
    check("s1_sck_rest", 32'(sck), 32'h0);
    step(1);
    check("s1_rsp_pulse", 32'(rsp_valid), 32'h0);
    check("s1_rsp_hold", 32'(rsp_data), 32'h5A5A3);
    step(1);

    // all four modes against the slave model
    loopback = 1'b0; sl_pat = 19'h3C96B; req_frame[0] = 19'h2B1D4;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      step(1);
      check("s2_idle_cpol", 32'(sck), 32'(m >> 1));
      req_valid = 2'b01;
      step(1);
      req_valid = 2'b00;
      check("s2_ss_low", 32'(ss_n), 32'h0);
      check("s2_setup_cpol", 32'(sck), 32'(m >> 1));
      wait_rsp("s2");
      check("s2_rsp_data", 32'(rsp_data), 32'h3C96B);
      check("s2_slave_rx", 32'(sl_rx), 32'h2B1D4);
      check("s2_gap_cpol", 32'(sck), 32'(m >> 1));
      step(2);
    end

    // round robin from reset with both requesters held
    mode = 2'b00; rst = 1'b1;
    step(1);
    rst = 1'b0; loopback = 1'b1;
    req_frame[0] = 19'h12345; req_frame[1] = 19'h6789A; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_rsp("s3");
      check("s3_rsp_id", 32'(rsp_id), 32'(k % 2));
      check("s3_rsp_data", 32'(rsp_data), (k % 2 == 0) ? 32'h12345 : 32'h6789A);
      if (k > 0) check("s3_gap_len", 32'(last_gap), 32'd2);
      if (k == 3) req_valid = 2'b00;
      step(1);
    end
    step(2);

    // mode change mid-frame applies to the next frame only
    loopback = 1'b0; mode = 2'b00; req_frame[0] = 19'h2B1D4;
    step(1);
    req_valid = 2'b01;
    step(1);
    req_valid = 2'b00;
    n = 0;
    while (sl_edges < 5 && n < 100) begin step(1); n++; end
    check("s4_reach_xfer", 32'(sl_edges >= 5), 32'h1);
    mode = 2'b11;
    wait_rsp("s4a");
    check("s4a_rsp_data", 32'(rsp_data), 32'h3C96B);
    check("s4a_slave_rx", 32'(sl_rx), 32'h2B1D4);
    check("s4a_sck_rest", 32'(sck), 32'h0);
    step(2);
    req_valid = 2'b01;
    step(1);
    req_valid = 2'b00;
    check("s4b_idle_cpol", 32'(sck), 32'h1);
    wait_rsp("s4b");
    check("s4b_rsp_data", 32'(rsp_data), 32'h3C96B);
    check("s4b_slave_rx", 32'(sl_rx), 32'h2B1D4);
    check("s4b_sck_rest", 32'(sck), 32'h1);
    step(2);

    // reset at the 10th sck edge aborts the frame
    mode = 2'b00;
    step(1);
    req_valid = 2'b01;
    step(1);
    req_valid = 2'b00;
    n = 0;
    while (sl_edges < 10 && n < 100) begin step(1); n++; end
    check("s5_edge10", 32'(sl_edges), 32'd10);
    rc = rsp_cnt;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("s5_ss_n", 32'(ss_n), 32'h1);
    check("s5_sck", 32'(sck), 32'h0);
    check("s5_busy", 32'(busy), 32'h0);
    step(60);
    check("s5_no_rsp", 32'(rsp_cnt), 32'(rc));
    req_valid = 2'b11;
    #1;
    check("s5_regrant0", 32'(req_ready), 32'h1);
    step(1);
    req_valid = 2'b00;
    wait_rsp("s5");
    check("s5_rsp_id", 32'(rsp_id), 32'h0);
    step(2);

    // back-to-back frames with a single requester
    req_frame1[0] = 19'h55AA3; req_valid1 = 1'b1;
    #1;
    t_prev = -1; pulses = 0;
    for (int c = 0; c < 400 && pulses < 4; c++) begin
      if (req_ready1 === 1'b1) begin
        if (t_prev >= 0) check("s6_interval", 32'(c - t_prev), 32'd83);
        t_prev = c;
        pulses++;
      end
      step(1);
    end
    check("s6_pulses", 32'(pulses), 32'd4);
    check("s6_rsp_data", 32'(rsp_data1), 32'h55AA3);
    req_valid1 = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
